// File: rtl/axi_lite_ram_slave.sv
// AXI-lite word-addressed RAM slave with local range/alignment checking and programmable access latency.
// Independent read and write FSMs share a dual-port 64-bit word array.
module axi_lite_ram_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = AXI_ADDR_WIDTH'(64'h8000_0000),
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  input  logic                        awvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        wvalid,
  input  logic                        bready,
  output logic                        awready,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic [AXI_ADDR_WIDTH-1:0]   araddr,
  input  logic                        arvalid,
  input  logic                        rready,
  output logic                        arready,
  output logic [AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                  rresp,
  output logic                        rvalid
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [AXI_ADDR_WIDTH-1:0] END_ADDR = BASE_ADDR + (AXI_ADDR_WIDTH'(DEPTH_WORDS) << 3);
  // Accept cycle counts as the first latency cycle, so the wait state holds LATENCY-1 further cycles
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  function automatic logic [1:0] decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
    if (addr < BASE_ADDR || addr >= END_ADDR) return RESP_DECERR;
    if (addr[2:0] != 3'b000) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return addr[IDX_W+2:3] - BASE_ADDR[IDX_W+2:3];
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  w_state_t                  w_state, w_next;
  logic [CNT_W-1:0]          w_cnt;
  logic [AXI_ADDR_WIDTH-1:0] w_addr, wc_addr;
  logic [AXI_DATA_WIDTH-1:0] w_data, wc_data;
  logic [STRB_W-1:0]         w_strb, wc_strb;
  logic                      w_load, w_dec, w_commit;
  logic [1:0]                wc_resp;

  r_state_t                  r_state, r_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, rc_addr;
  logic                      r_load, r_dec, r_sample;
  logic [1:0]                rc_resp;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write channel: with zero latency the commit uses the live AW/W payload directly
  always_comb begin
    w_next   = w_state;
    awready  = 1'b0;
    wready   = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_commit = 1'b0;
    wc_addr  = w_addr;
    wc_data  = w_data;
    wc_strb  = w_strb;
    case (w_state)
      W_IDLE: begin
        wc_addr = awaddr;
        wc_data = wdata;
        wc_strb = wstrb;
        if (awvalid && wvalid) begin
          awready = 1'b1;
          wready  = 1'b1;
          w_load  = 1'b1;
          if (LATENCY == 0) begin
            w_commit = 1'b1;
            w_next   = W_RESP;
          end else begin
            w_next = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = W_RESP;
        end else begin
          w_dec = 1'b1;
        end
      end
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign wc_resp = decode(wc_addr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_cnt  <= '0;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else begin
      if (w_load) begin
        w_addr <= awaddr;
        w_data <= wdata;
        w_strb <= wstrb;
        w_cnt  <= CNT_INIT;
      end else if (w_dec) begin
        w_cnt <= w_cnt - 1'b1;
      end
      if (w_commit) begin
        bvalid <= 1'b1;
        bresp  <= wc_resp;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && w_commit && wc_resp == RESP_OKAY) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wc_strb[i]) mem[word_index(wc_addr)][8*i +: 8] <= wc_data[8*i +: 8];
      end
    end
  end

  // Read channel mirrors the write channel; arready depends only on state
  always_comb begin
    r_next   = r_state;
    arready  = 1'b0;
    r_load   = 1'b0;
    r_dec    = 1'b0;
    r_sample = 1'b0;
    rc_addr  = r_addr;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        rc_addr = araddr;
        if (arvalid) begin
          r_load = 1'b1;
          if (LATENCY == 0) begin
            r_sample = 1'b1;
            r_next   = R_RESP;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == '0) begin
          r_sample = 1'b1;
          r_next   = R_RESP;
        end else begin
          r_dec = 1'b1;
        end
      end
      R_RESP: if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign rc_resp = decode(rc_addr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt  <= '0;
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else begin
      if (r_load) begin
        r_addr <= araddr;
        r_cnt  <= CNT_INIT;
      end else if (r_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_sample) begin
        rvalid <= 1'b1;
        rresp  <= rc_resp;
        rdata  <= (rc_resp == RESP_OKAY) ? mem[word_index(rc_addr)] : '0;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed self-checking bench: LATENCY=1 instance for main traffic, LATENCY=0 instance for collisions.
module tb_axi_lite_ram_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic        awvalid, wvalid, bready, awready, wready, bvalid;
  logic        arvalid, rready, arready, rvalid;
  logic [1:0]  bresp, rresp;

  logic [63:0] c_awaddr, c_wdata, c_araddr, c_rdata;
  logic [7:0]  c_wstrb;
  logic        c_awvalid, c_wvalid, c_bready, c_awready, c_wready, c_bvalid;
  logic        c_arvalid, c_rready, c_arready, c_rvalid;
  logic [1:0]  c_bresp, c_rresp;

  int checks = 0;
  int errors = 0;

  axi_lite_ram_slave #(.LATENCY(1)) u_dut (
    .clk(clk), .rstn(rstn),
    .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .bready(bready), .awready(awready), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .araddr(araddr), .arvalid(arvalid), .rready(rready), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid)
  );

  axi_lite_ram_slave #(.LATENCY(0)) u_col (
    .clk(clk), .rstn(rstn),
    .awaddr(c_awaddr), .awvalid(c_awvalid), .wdata(c_wdata), .wstrb(c_wstrb), .wvalid(c_wvalid),
    .bready(c_bready), .awready(c_awready), .wready(c_wready), .bresp(c_bresp), .bvalid(c_bvalid),
    .araddr(c_araddr), .arvalid(c_arvalid), .rready(c_rready), .arready(c_arready),
    .rdata(c_rdata), .rresp(c_rresp), .rvalid(c_rvalid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge; lat is the cycle offset of bvalid from accept
  task automatic write_txn(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp, output int lat);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic read_txn(input logic [63:0] a, output logic [63:0] d,
                          output logic [1:0] resp, output int lat);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rdata;
    resp = rresp;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [63:0] data;
    int          lat;

    // Reset with every valid asserted
    rstn = 1'b0;
    awaddr = BASE + 64'h40; wdata = 64'h5555_5555_5555_5555; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = BASE; arvalid = 1'b1; rready = 1'b1;
    c_awaddr = BASE; c_wdata = '0; c_wstrb = 8'hFF; c_awvalid = 1'b1; c_wvalid = 1'b1; c_bready = 1'b1;
    c_araddr = BASE; c_arvalid = 1'b1; c_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_col_bvalid", 64'(c_bvalid), 64'd0);
    rstn = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    c_awvalid = 1'b0; c_wvalid = 1'b0; c_arvalid = 1'b0;
    check("rst_arready_after", 64'(arready), 64'd1);

    // Basic write/read at LATENCY=1
    write_txn(BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, resp, lat);
    check("wr_lat", 64'(lat), 64'd2);
    check("wr_bresp", 64'(resp), 64'd0);
    read_txn(BASE + 64'h10, data, resp, lat);
    check("rd_lat", 64'(lat), 64'd2);
    check("rd_rresp", 64'(resp), 64'd0);
    check("rd_data", data, 64'h1122_3344_5566_7788);

    // Partial strobe
    write_txn(BASE + 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, resp, lat);
    check("strb_bresp", 64'(resp), 64'd0);
    read_txn(BASE + 64'h10, data, resp, lat);
    check("strb_data", data, 64'h1122_3344_AAAA_AAAA);

    // Error responses and writes that must not touch memory
    write_txn(64'h7FFF_FFF8, 64'h0, 8'hFF, resp, lat);
    check("oor_wr_bresp", 64'(resp), 64'd3);
    write_txn(BASE + 64'h11, 64'h0, 8'hFF, resp, lat);
    check("mis_wr_bresp", 64'(resp), 64'd2);
    write_txn(BASE + 64'h10, 64'h0, 8'h00, resp, lat);
    check("zstrb_bresp", 64'(resp), 64'd0);
    read_txn(BASE + 64'h10, data, resp, lat);
    check("err_untouched", data, 64'h1122_3344_AAAA_AAAA);
    read_txn(BASE + 64'h4, data, resp, lat);
    check("mis_rd_rresp", 64'(resp), 64'd2);
    check("mis_rd_rdata", data, 64'd0);
    read_txn(BASE + 64'h8000, data, resp, lat);
    check("end_rd_rresp", 64'(resp), 64'd3);
    check("end_rd_rdata", data, 64'd0);
    read_txn(64'h7FFF_FFF8, data, resp, lat);
    check("below_rd_rresp", 64'(resp), 64'd3);

    // Last word in the window is valid
    write_txn(BASE + 64'h7FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, resp, lat);
    check("last_wr_bresp", 64'(resp), 64'd0);
    read_txn(BASE + 64'h7FF8, data, resp, lat);
    check("last_rd_rresp", 64'(resp), 64'd0);
    check("last_rd_data", data, 64'hDEAD_BEEF_CAFE_F00D);

    // Read backpressure
    araddr = BASE + 64'h10; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 64'(rvalid), 64'd1);
      check("bp_rdata", rdata, 64'h1122_3344_AAAA_AAAA);
      check("bp_rresp", 64'(rresp), 64'd0);
      check("bp_arready", 64'(arready), 64'd0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    check("bp_arready_after", 64'(arready), 64'd1);
    check("bp_rvalid_after", 64'(rvalid), 64'd0);

    // Reset abandons a write accepted but not yet committed
    write_txn(BASE + 64'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, resp, lat);
    check("pre_rst_bresp", 64'(resp), 64'd0);
    awaddr = BASE + 64'h20; wdata = 64'hFFFF_0000_FFFF_0000; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    wdata = 64'h0F0F_0F0F_0F0F_0F0F; arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_bvalid", 64'(bvalid), 64'd0);
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    rstn = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("mid_rst_arready", 64'(arready), 64'd1);
    read_txn(BASE + 64'h20, data, resp, lat);
    check("mid_rst_dropped", data, 64'h0123_4567_89AB_CDEF);

    // Same-edge write commit and read sample at LATENCY=0
    c_awaddr = BASE + 64'h18; c_wdata = 64'h0000_0000_0000_0A0A; c_wstrb = 8'hFF;
    c_awvalid = 1'b1; c_wvalid = 1'b1; c_bready = 1'b1; c_rready = 1'b1;
    @(posedge clk); #1;
    c_awvalid = 1'b0; c_wvalid = 1'b0;
    check("col_pre_bvalid", 64'(c_bvalid), 64'd1);
    check("col_pre_bresp", 64'(c_bresp), 64'd0);
    @(posedge clk); #1;
    c_wdata = 64'h0000_0000_0000_0B0B; c_awvalid = 1'b1; c_wvalid = 1'b1;
    c_araddr = BASE + 64'h18; c_arvalid = 1'b1;
    @(posedge clk); #1;
    c_awvalid = 1'b0; c_wvalid = 1'b0; c_arvalid = 1'b0;
    check("col_bvalid", 64'(c_bvalid), 64'd1);
    check("col_rvalid", 64'(c_rvalid), 64'd1);
    check("col_rdata_old", c_rdata, 64'h0000_0000_0000_0A0A);
    @(posedge clk); #1;
    c_arvalid = 1'b1;
    @(posedge clk); #1;
    c_arvalid = 1'b0;
    check("col_rvalid_later", 64'(c_rvalid), 64'd1);
    check("col_rdata_new", c_rdata, 64'h0000_0000_0000_0B0B);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
